// File: rtl/jtcop_sec_pkg.sv
// rtl/jtcop_sec_pkg.sv - shared constants and types for the security mailbox responder
package jtcop_sec_pkg;

    // MCU register map
    localparam logic [1:0] SEC_DLO  = 2'd0;
    localparam logic [1:0] SEC_DHI  = 2'd1;
    localparam logic [1:0] SEC_STAT = 2'd2;
    localparam logic [1:0] SEC_CTRL = 2'd3;

    // status byte bit positions
    localparam int STAT_IN_NE   = 0;
    localparam int STAT_SEC2    = 1;
    localparam int STAT_IN_OVR  = 2;
    localparam int STAT_OUT_OVR = 3;

    // control byte: writing 1 here clears both sticky overflow flags
    localparam int CTRL_CLR_OVR = 0;

    // reply handshake towards the main CPU
    typedef enum logic [1:0] {
        RPL_IDLE  = 2'd0,
        RPL_READY = 2'd1,
        RPL_REARM = 2'd2
    } reply_state_t;

    // REARM holds sec2 low for two clocks: counter value on its last cycle
    localparam logic REARM_LAST = 1'b1;

    function automatic logic [7:0] pack_status(input logic out_ovr, input logic in_ovr,
                                               input logic sec2, input logic in_ne);
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_IN_NE]   = in_ne;
        s[STAT_SEC2]    = sec2;
        s[STAT_IN_OVR]  = in_ovr;
        s[STAT_OUT_OVR] = out_ovr;
        return s;
    endfunction

endpackage

// File: rtl/jtcop_sec_fifo.sv
// rtl/jtcop_sec_fifo.sv - inbound word FIFO used when JTCOP_SEC_FIFO_EN is defined
module jtcop_sec_fifo
    import jtcop_sec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovr
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovr     = push & full & ~do_pop;
    assign dout    = mem[rd_ptr];

    // storage array, no reset needed: contents are only visible through the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {AW'(0), do_push} - {AW'(0), do_pop};
        end
    end

endmodule

// File: rtl/jtcop_sec_resp.sv
// rtl/jtcop_sec_resp.sv - MCU-side security mailbox responder; JTCOP_SEC_FIFO_EN selects a DEPTH-word inbound FIFO
module jtcop_sec_resp
    import jtcop_sec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic [5:0]  sec,
    input  logic [15:0] mcu_din,
    output logic [15:0] mcu_dout,
    output logic        sec2,
    input  logic [1:0]  mcu_addr,
    input  logic        mcu_wr,
    input  logic        mcu_rd,
    input  logic [7:0]  mcu_wdata,
    output logic [7:0]  mcu_rdata,
    output logic        mcu_irq
);

    logic [1:0]   sec_l;
    logic         wr_fall;
    logic         rd_fall;
    logic         pop;
    logic         commit;
    logic         clr_ovr;
    logic         in_ne;
    logic         in_ovr;
    logic         out_ovr;
    logic [15:0]  in_word;
    logic [7:0]   lo_hold;
    reply_state_t state;
    reply_state_t state_nx;
    logic         rearm_cnt;
    logic         sec_unused;

    // only the write and read strobes matter to this block
    assign sec_unused = ^sec[5:2];

    assign wr_fall = sec_l[0] & ~sec[0];
    assign rd_fall = sec_l[1] & ~sec[1];
    assign pop     = mcu_rd && (mcu_addr == SEC_DHI);
    assign commit  = mcu_wr && (mcu_addr == SEC_DHI);
    assign clr_ovr = mcu_wr && (mcu_addr == SEC_CTRL) && mcu_wdata[CTRL_CLR_OVR];

    // registered copy of the main strobes for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sec_l <= 2'b00;
        else     sec_l <= sec[1:0];
    end

`ifdef JTCOP_SEC_FIFO_EN
    logic fifo_empty;
    logic fifo_full_unused;
    logic fifo_ovr;

    jtcop_sec_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .rst   (rst),
        .clk   (clk),
        .push  (wr_fall),
        .pop   (pop),
        .din   (mcu_din),
        .dout  (in_word),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .ovr   (fifo_ovr)
    );

    assign in_ne = ~fifo_empty;

    // sticky inbound overflow: a dropped word wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           in_ovr <= 1'b0;
        else if (fifo_ovr) in_ovr <= 1'b1;
        else if (clr_ovr)  in_ovr <= 1'b0;
    end
`else
    logic        in_full;
    logic [15:0] in_data;
    logic [31:0] depth_unused;

    assign depth_unused = DEPTH;
    assign in_ne        = in_full;
    assign in_word      = in_data;

    // single-word mailbox: pop is applied before push, overwrite of unread data flags in_ovr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_full <= 1'b0;
            in_data <= 16'h0000;
            in_ovr  <= 1'b0;
        end else begin
            if (wr_fall) begin
                in_data <= mcu_din;
                in_full <= 1'b1;
            end else if (pop) begin
                in_full <= 1'b0;
            end
            if (wr_fall && in_full && !pop) in_ovr <= 1'b1;
            else if (clr_ovr)               in_ovr <= 1'b0;
        end
    end
`endif

    assign mcu_irq = in_ne;

    // reply assembly: low byte is held until the high-byte write commits the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_hold  <= 8'h00;
            mcu_dout <= 16'h0000;
            out_ovr  <= 1'b0;
        end else begin
            if (mcu_wr && (mcu_addr == SEC_DLO)) lo_hold <= mcu_wdata;
            if (commit) mcu_dout <= {mcu_wdata, lo_hold};
            if (commit && (state == RPL_READY)) out_ovr <= 1'b1;
            else if (clr_ovr)                   out_ovr <= 1'b0;
        end
    end

    // registered MCU read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcu_rdata <= 8'h00;
        end else if (mcu_rd) begin
            case (mcu_addr)
                SEC_DLO:  mcu_rdata <= in_word[7:0];
                SEC_DHI:  mcu_rdata <= in_word[15:8];
                SEC_STAT: mcu_rdata <= pack_status(out_ovr, in_ovr, sec2, in_ne);
                default:  mcu_rdata <= 8'h00;
            endcase
        end
    end

    // reply state register and REARM cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RPL_IDLE;
            rearm_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            rearm_cnt <= ((state == RPL_REARM) && (state_nx == RPL_REARM)) ? ~rearm_cnt : 1'b0;
        end
    end

    // reply next state: a commit always beats a same-cycle main read
    always_comb begin
        state_nx = state;
        case (state)
            RPL_IDLE: begin
                if (commit) state_nx = RPL_READY;
            end
            RPL_READY: begin
                if (commit && rd_fall) state_nx = RPL_READY;
                else if (commit)       state_nx = RPL_REARM;
                else if (rd_fall)      state_nx = RPL_IDLE;
            end
            RPL_REARM: begin
                if (commit)                         state_nx = RPL_READY;
                else if (rd_fall)                   state_nx = RPL_IDLE;
                else if (rearm_cnt == REARM_LAST)   state_nx = RPL_READY;
            end
            default: state_nx = RPL_IDLE;
        endcase
    end

    // reply outputs: sec2 is high only while a reply waits in READY
    always_comb begin
        sec2 = 1'b0;
        if (state == RPL_READY) sec2 = 1'b1;
    end

endmodule

// File: tb/tb_jtcop_sec_resp.sv
// tb/tb_jtcop_sec_resp.sv - directed self-checking bench for jtcop_sec_resp
module tb_jtcop_sec_resp;

    logic        rst;
    logic        clk;
    logic [5:0]  sec;
    logic [15:0] mcu_din;
    logic [15:0] mcu_dout;
    logic        sec2;
    logic [1:0]  mcu_addr;
    logic        mcu_wr;
    logic        mcu_rd;
    logic [7:0]  mcu_wdata;
    logic [7:0]  mcu_rdata;
    logic        mcu_irq;

    int checks = 0;
    int errors = 0;

    jtcop_sec_resp #(.DEPTH(4)) dut (
        .rst       (rst),
        .clk       (clk),
        .sec       (sec),
        .mcu_din   (mcu_din),
        .mcu_dout  (mcu_dout),
        .sec2      (sec2),
        .mcu_addr  (mcu_addr),
        .mcu_wr    (mcu_wr),
        .mcu_rd    (mcu_rd),
        .mcu_wdata (mcu_wdata),
        .mcu_rdata (mcu_rdata),
        .mcu_irq   (mcu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns at the negedge where sec[0] has just fallen, before the detecting edge
    task automatic main_write(input logic [15:0] d);
        @(negedge clk);
        mcu_din = d;
        sec[0]  = 1'b1;
        repeat (4) @(negedge clk);
        sec[0]  = 1'b0;
    endtask

    // returns at the negedge where sec[1] has just fallen
    task automatic main_read();
        @(negedge clk);
        sec[1] = 1'b1;
        repeat (2) @(negedge clk);
        sec[1] = 1'b0;
    endtask

    task automatic mcu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        mcu_addr = a;
        mcu_rd   = 1'b1;
        @(negedge clk);
        mcu_rd   = 1'b0;
        d        = mcu_rdata;
    endtask

    task automatic mcu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        mcu_addr  = a;
        mcu_wdata = d;
        mcu_wr    = 1'b1;
        @(negedge clk);
        mcu_wr    = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mcu_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", mcu_dout); end
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL reset_sec2 got %b want 0", sec2); end
        checks++; if (mcu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", mcu_rdata); end
        checks++; if (mcu_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", mcu_irq); end
    endtask

    task automatic test_main_write(input string tag);
        logic [7:0] d;
        main_write(16'hA55A);
        checks++; if (mcu_irq !== 1'b0) begin errors++; $display("FAIL %s_irq_early got %b want 0", tag, mcu_irq); end
        @(negedge clk);
        checks++; if (mcu_irq !== 1'b1) begin errors++; $display("FAIL %s_irq_set got %b want 1", tag, mcu_irq); end
        mcu_read(2'd0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL %s_lo got %h want 5a", tag, d); end
        checks++; if (mcu_irq !== 1'b1) begin errors++; $display("FAIL %s_irq_after_lo got %b want 1", tag, mcu_irq); end
        mcu_read(2'd1, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL %s_hi got %h want a5", tag, d); end
        checks++; if (mcu_irq !== 1'b0) begin errors++; $display("FAIL %s_irq_clear got %b want 0", tag, mcu_irq); end
    endtask

    task automatic test_reply();
        mcu_write(2'd0, 8'h34);
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL reply_sec2_pre got %b want 0", sec2); end
        mcu_write(2'd1, 8'h12);
        checks++; if (mcu_dout !== 16'h1234) begin errors++; $display("FAIL reply_dout got %h want 1234", mcu_dout); end
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL reply_sec2_rise got %b want 1", sec2); end
        main_read();
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL reply_sec2_hold got %b want 1", sec2); end
        @(negedge clk);
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL reply_sec2_clear got %b want 0", sec2); end
        checks++; if (mcu_dout !== 16'h1234) begin errors++; $display("FAIL reply_dout_hold got %h want 1234", mcu_dout); end
    endtask

    task automatic test_rearm();
        logic [7:0] d;
        mcu_write(2'd0, 8'h78);
        mcu_write(2'd1, 8'h56);
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL rearm_p0 got %b want 1", sec2); end
        mcu_write(2'd0, 8'hBC);
        mcu_write(2'd1, 8'h9A);
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL rearm_p1 got %b want 0", sec2); end
        checks++; if (mcu_dout !== 16'h9ABC) begin errors++; $display("FAIL rearm_dout got %h want 9abc", mcu_dout); end
        @(negedge clk);
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL rearm_p2 got %b want 0", sec2); end
        @(negedge clk);
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL rearm_p3 got %b want 1", sec2); end
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h0A) begin errors++; $display("FAIL rearm_status got %h want 0a", d); end
        mcu_write(2'd3, 8'h01);
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL rearm_status_clr got %h want 02", d); end
        main_read();
        @(negedge clk);
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL rearm_idle got %b want 0", sec2); end
    endtask

`ifdef JTCOP_SEC_FIFO_EN
    task automatic test_fifo();
        logic [7:0] d;
        for (int i = 1; i <= 5; i++) main_write(16'(i));
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            mcu_read(2'd0, d);
            checks++; if (d !== 8'(i)) begin errors++; $display("FAIL fifo_pop%0d got %h want %h", i, d, 8'(i)); end
            mcu_read(2'd1, d);
        end
        checks++; if (mcu_irq !== 1'b0) begin errors++; $display("FAIL fifo_empty_irq got %b want 0", mcu_irq); end
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL fifo_status got %h want 04", d); end
        mcu_write(2'd3, 8'h01);
    endtask
`else
    task automatic test_overwrite();
        logic [7:0] d;
        main_write(16'h0001);
        main_write(16'h0002);
        @(negedge clk);
        checks++; if (mcu_irq !== 1'b1) begin errors++; $display("FAIL ovw_irq got %b want 1", mcu_irq); end
        mcu_read(2'd0, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovw_lo got %h want 02", d); end
        mcu_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovw_hi got %h want 00", d); end
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL ovw_status got %h want 04", d); end
        mcu_write(2'd3, 8'h01);
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovw_status_clr got %h want 00", d); end
    endtask
`endif

    task automatic test_pop_push();
        logic [7:0] d;
        main_write(16'h1111);
        @(negedge clk);
        mcu_din = 16'h2222;
        sec[0]  = 1'b1;
        repeat (3) @(negedge clk);
        sec[0]   = 1'b0;
        mcu_addr = 2'd1;
        mcu_rd   = 1'b1;
        @(negedge clk);
        mcu_rd   = 1'b0;
        checks++; if (mcu_rdata !== 8'h11) begin errors++; $display("FAIL pp_old_hi got %h want 11", mcu_rdata); end
        checks++; if (mcu_irq !== 1'b1) begin errors++; $display("FAIL pp_irq got %b want 1", mcu_irq); end
        mcu_read(2'd0, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL pp_new_lo got %h want 22", d); end
        mcu_read(2'd1, d);
        mcu_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL pp_status got %h want 00", d); end
    endtask

    task automatic test_commit_read();
        mcu_write(2'd0, 8'h55);
        mcu_write(2'd1, 8'h66);
        @(negedge clk);
        sec[1] = 1'b1;
        mcu_write(2'd0, 8'h88);
        sec[1]    = 1'b0;
        mcu_addr  = 2'd1;
        mcu_wdata = 8'h77;
        mcu_wr    = 1'b1;
        @(negedge clk);
        mcu_wr    = 1'b0;
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL cr_sec2 got %b want 1", sec2); end
        checks++; if (mcu_dout !== 16'h7788) begin errors++; $display("FAIL cr_dout got %h want 7788", mcu_dout); end
        repeat (2) @(negedge clk);
        checks++; if (sec2 !== 1'b1) begin errors++; $display("FAIL cr_sec2_stay got %b want 1", sec2); end
        main_read();
        mcu_write(2'd3, 8'h01);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        main_write(16'hBEEF);
        @(negedge clk);
        mcu_read(2'd0, d);
        mcu_write(2'd0, 8'h11);
        mcu_write(2'd1, 8'h22);
        checks++; if (sec2 !== 1'b1 || mcu_irq !== 1'b1) begin errors++; $display("FAIL rm_pre got sec2=%b irq=%b want 1 1", sec2, mcu_irq); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mcu_dout !== 16'h0000) begin errors++; $display("FAIL rm_dout got %h want 0000", mcu_dout); end
        checks++; if (sec2 !== 1'b0) begin errors++; $display("FAIL rm_sec2 got %b want 0", sec2); end
        checks++; if (mcu_rdata !== 8'h00) begin errors++; $display("FAIL rm_rdata got %h want 00", mcu_rdata); end
        checks++; if (mcu_irq !== 1'b0) begin errors++; $display("FAIL rm_irq got %b want 0", mcu_irq); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_main_write("rm_again");
    endtask

    initial begin
        rst       = 1'b1;
        sec       = 6'b0;
        mcu_din   = 16'h0000;
        mcu_addr  = 2'd0;
        mcu_wr    = 1'b0;
        mcu_rd    = 1'b0;
        mcu_wdata = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_main_write("mw");
        test_reply();
        test_rearm();
`ifdef JTCOP_SEC_FIFO_EN
        test_fifo();
`else
        test_overwrite();
`endif
        test_pop_push();
        test_commit_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
